// File: rtl/sn_pkg.sv
// Shared stochastic-number definitions: APC state encoding, width helper and
// the default stream length that the SNG stages also use.
package sn_pkg;

  localparam int SN_WIN_LEN_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } apc_state_t;

  // Ceiling log2, usable in constant (parameter) context.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sn_popcount.sv
// Combinational population count of N_LANE stochastic bits.
module sn_popcount
  import sn_pkg::*;
#(
  parameter int N_LANE = 4,
  parameter int PC_W   = clog2_f(N_LANE + 1)
) (
  input  logic [N_LANE-1:0] bits,
  output logic [PC_W-1:0]   count
);

  // Lane-by-lane sum; synthesis rebalances the chain into an adder tree.
  always_comb begin
    count = {PC_W{1'b0}};
    for (int i = 0; i < N_LANE; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/sn_apc_counter.sv
// Accumulative parallel counter: pop-counts N_LANE stochastic streams over a
// WIN_LEN-cycle window and presents the total on a valid/ready output.
// Build option SN_BIPOLAR_EN: result is two's complement 2*ones - N_LANE*WIN_LEN.
module sn_apc_counter
  import sn_pkg::*;
#(
  parameter int N_LANE  = 4,
  parameter int WIN_LEN = SN_WIN_LEN_DEFAULT,
  parameter int ACC_W   = clog2_f(N_LANE * WIN_LEN + 1)
) (
  input  logic              i_clk_apc,
  input  logic              i_rst_apc,
  input  logic [N_LANE-1:0] i_sn_bits,
  input  logic              i_start_apc,
  input  logic              i_stop_apc,
  input  logic              i_bn_ready,
`ifdef SN_BIPOLAR_EN
  output logic [ACC_W:0]    o_bn_data,
`else
  output logic [ACC_W-1:0]  o_bn_data,
`endif
  output logic              o_bn_valid,
  output logic              o_busy
);

`ifdef SN_BIPOLAR_EN
  localparam int OUT_W = ACC_W + 1;
`else
  localparam int OUT_W = ACC_W;
`endif
  localparam int PC_W  = clog2_f(N_LANE + 1);
  localparam int CNT_W = (WIN_LEN > 1) ? clog2_f(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ACC  = ACC;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [PC_W-1:0]  pc_s;
  logic [ACC_W-1:0] sum_s;
  logic [OUT_W-1:0] result_s;
  logic [1:0]       state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [OUT_W-1:0] bn_data_r;
  logic             bn_valid_r;
  logic             busy_r;

  sn_popcount #(
    .N_LANE (N_LANE),
    .PC_W   (PC_W)
  ) u_popcount (
    .bits  (i_sn_bits),
    .count (pc_s)
  );

  // Running total including the current cycle's lanes, and its output coding.
  always_comb begin
    sum_s = acc_r + ACC_W'(pc_s);
`ifdef SN_BIPOLAR_EN
    result_s = {sum_s, 1'b0} - OUT_W'(N_LANE * WIN_LEN);
`else
    result_s = sum_s;
`endif
  end

  // Window control FSM with accumulator, sample counter and output registers.
  always_ff @(posedge i_clk_apc) begin
    if (i_rst_apc) begin
      state_r    <= ST_IDLE;
      acc_r      <= {ACC_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      bn_data_r  <= {OUT_W{1'b0}};
      bn_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start_apc) begin
            state_r <= ST_ACC;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACC: begin
          // Abort wins over the final sample: no result escapes a stopped window.
          if (i_stop_apc) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == LAST_IDX) begin
            bn_data_r  <= result_s;
            bn_valid_r <= 1'b1;
            state_r    <= ST_HOLD;
            busy_r     <= 1'b0;
          end else begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (i_bn_ready) begin
            bn_valid_r <= 1'b0;
            if (i_start_apc) begin
              state_r <= ST_ACC;
              acc_r   <= {ACC_W{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (i_stop_apc) begin
            bn_valid_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          bn_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign o_bn_data  = bn_data_r;
  assign o_bn_valid = bn_valid_r;
  assign o_busy     = busy_r;

endmodule
